// File: rtl/tengbe_txsnap_seq.sv
// tengbe_txsnap_seq: capture sequencer for the 10GbE TX snapshot path.
// Software arms through ctrl_in, the sequencer waits for a trigger and then
// writes a contiguous run of TX words into the snapshot BRAM, reporting
// progress on status_out.
// Optional feature macro: TXSNAP_STOP_EOF_EN (ctrl_in[3] ends capture on the
// written end-of-frame word). Without it ctrl_in[3] is ignored.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | out of reset, nothing armed
// S_ARMED   | armed, waiting for trigger (immediate or frame start)
// S_CAPTURE | writing qualified TX words to the BRAM
// S_DONE    | buffer full (or EOF stop), holds until the next arm edge
module tengbe_txsnap_seq #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl_in,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_eof,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       status_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d, count_inc;
  logic              arm_q;
  logic              sof_flag_q;
  logic              arm_rise, frame_start, trig, wq, eof_stop, wr_en;
  logic [31:0]       status_d;

`ifdef TXSNAP_STOP_EOF_EN
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_in[31:4];
  assign eof_stop    = ctrl_in[3] & tx_valid & tx_eof;
`else
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_in[31:3];
  assign eof_stop    = 1'b0;
`endif

  // trigger / qualifier decode; trig_sel and we_sel act on the current cycle
  assign arm_rise    = ctrl_in[0] & ~arm_q;
  assign frame_start = tx_valid & sof_flag_q;
  assign trig        = ctrl_in[1] ? frame_start : 1'b1;
  assign wq          = ctrl_in[2] ? tx_valid : 1'b1;
  assign count_inc   = (count_q == DEPTH) ? count_q : count_q + CNT_ONE;

  // next state, write request and count; an arm edge overrides everything
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (arm_rise) begin
      state_d = S_ARMED;
      count_d = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (trig) begin
            state_d = S_CAPTURE;
            wr_en   = wq;
          end
        end
        S_CAPTURE: wr_en = wq;
        default:   wr_en = 1'b0;
      endcase
      if (wr_en) begin
        count_d = count_inc;
        if ((count_inc == DEPTH) || eof_stop) begin
          state_d = S_DONE;
        end
      end
    end
  end

  // status is built from next-state values so it lands with the final write
  always_comb begin
    status_d             = '0;
    status_d[31]         = (state_d == S_DONE);
    status_d[30]         = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    status_d[ADDR_W:0]   = count_d;
  end

  // state, frame tracking, BRAM write port and status registers
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      arm_q      <= 1'b0;
      sof_flag_q <= 1'b1;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_data  <= '0;
      status_out <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      arm_q      <= ctrl_in[0];
      if (tx_valid) begin
        sof_flag_q <= tx_eof;
      end
      bram_we    <= wr_en;
      if (wr_en) begin
        bram_addr <= count_q[ADDR_W-1:0];
        bram_data <= tx_data;
      end
      status_out <= status_d;
    end
  end

endmodule
